// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-requester Wishbone B4 arbiter onto one shared bus.
// m0 (instruction fetch) and m1 (load/store) share downstream port s.
// Grants are non-preemptive, one cycle after CYC is seen in IDLE. Ties
// alternate, with m0 first after reset.
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall watchdog. After
// TIMEOUT_CYCLES stalled strobe cycles it terminates the owner with ERR.
//
// Handshake: a beat transfers on a cycle where CYC & STB are high and the
// slave raises exactly one of ACK/ERR/RTY. The requester holds ADR/DAT_O/
// WE/CTI_O stable until then. CYC frames the whole (possibly burst) cycle.
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  input  logic [2:0]  m0_cti_o,
  output logic [31:0] m0_dat_i,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  // requester 1
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  input  logic [2:0]  m1_cti_o,
  output logic [31:0] m1_dat_i,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  // shared downstream bus
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_cti_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  // FSM state: 0 = IDLE, 1 = GNT0, 2 = GNT1
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_next;
  // 1 = m1 owned the bus last (reset value, so m0 wins the first tie)
  logic   last_owner, last_next;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt, tmo_cnt_next;
  logic       stalled, tmo_hit;
`endif

  // State, last-owner and watchdog registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt    <= 8'd0;
`endif
    end else begin
      state      <= state_next;
      last_owner <= last_next;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_next;
`endif
    end
  end

  // Next-state selection and combinational routing of the granted requester
  always_comb begin
    state_next = state;
    last_next  = last_owner;
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = 32'd0;
    s_dat_o    = 32'd0;
    s_cti_o    = 3'd0;
    m0_dat_i   = s_dat_i;
    m1_dat_i   = s_dat_i;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_rty     = 1'b0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_rty     = 1'b0;
    case (state)
      IDLE: begin
        // STB without CYC is not a request; only CYC is looked at here
        if (m0_cyc && m1_cyc) state_next = last_owner ? GNT0 : GNT1;
        else if (m0_cyc)      state_next = GNT0;
        else if (m1_cyc)      state_next = GNT1;
      end
      GNT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_cyc & m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_o = m0_dat_o;
        s_cti_o = m0_cti_o;
        m0_ack  = s_ack;
        m0_err  = s_err;
        m0_rty  = s_rty;
        if (!m0_cyc) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      GNT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_cyc & m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_o = m1_dat_o;
        s_cti_o = m1_cti_o;
        m1_ack  = s_ack;
        m1_err  = s_err;
        m1_rty  = s_rty;
        if (!m1_cyc) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    // Stall = owner strobing with no termination. On the last allowed
    // stalled cycle, withdraw STB from the slave and terminate the owner.
    stalled      = (state != IDLE) && s_stb && !s_ack && !s_err && !s_rty;
    tmo_hit      = stalled && (tmo_cnt == TMO_LAST);
    tmo_cnt_next = 8'd0;
    if (stalled && !tmo_hit) tmo_cnt_next = (tmo_cnt == 8'hff) ? tmo_cnt : tmo_cnt + 8'd1;
    if (tmo_hit) begin
      s_stb = 1'b0;
      if (state == GNT0) m0_err = 1'b1;
      else               m1_err = 1'b1;
    end
`endif
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level ownership model (who owns the bus, who
// owned it last, how long the owner has stalled).
module tb_wb_arbiter2;
  localparam int TMO = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // requester stimulus, index = requester number
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2], md[2];
  logic [2:0]  mt[2];
  // slave stimulus
  logic [31:0] sd;
  logic        sa, se, sr;

  logic [31:0] m0_dat_i, m1_dat_i;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model: owner -1 = nobody, else requester index
  int   owner, last;
  logic tmo;
`ifdef WB_ARB_TIMEOUT_EN
  int   cnt;
`endif
  logic [31:0] exp_q[$];

  wb_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_adr(ma[0]), .m0_dat_o(md[0]),
    .m0_cti_o(mt[0]), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_adr(ma[1]), .m1_dat_o(md[1]),
    .m1_cti_o(mt[1]), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_cti_o(s_cti_o), .s_dat_i(sd), .s_ack(sa), .s_err(se), .s_rty(sr),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_m(input int i, input logic c, input logic st, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    mc[i] = c; ms[i] = st; mw[i] = w; ma[i] = a; md[i] = d; mt[i] = t;
  endtask

  task automatic set_s(input logic a, input logic e, input logic r, input logic [31:0] d);
    sa = a; se = e; sr = r; sd = d;
  endtask

  // One clock: compare all outputs against the model, then advance the model
  task automatic cycle();
    logic        e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    logic [2:0]  e_cti;
    #1;
    tmo = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    if (owner >= 0)
      if (mc[owner] && ms[owner] && !(sa || se || sr) && cnt == TMO - 1) tmo = 1'b1;
`endif
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_cti = '0;
    if (owner >= 0) begin
      e_cyc = mc[owner];
      e_stb = mc[owner] & ms[owner] & ~tmo;
      e_we  = mw[owner];
      e_adr = ma[owner];
      e_dat = md[owner];
      e_cti = mt[owner];
    end
    check("s_cyc", 32'(s_cyc), 32'(e_cyc));
    check("s_stb", 32'(s_stb), 32'(e_stb));
    check("s_we", 32'(s_we), 32'(e_we));
    check("s_adr", s_adr, e_adr);
    check("s_dat_o", s_dat_o, e_dat);
    check("s_cti_o", 32'(s_cti_o), 32'(e_cti));
    check("m0_ack", 32'(m0_ack), 32'((owner == 0) & sa));
    check("m0_err", 32'(m0_err), 32'((owner == 0) & (se | tmo)));
    check("m0_rty", 32'(m0_rty), 32'((owner == 0) & sr));
    check("m1_ack", 32'(m1_ack), 32'((owner == 1) & sa));
    check("m1_err", 32'(m1_err), 32'((owner == 1) & (se | tmo)));
    check("m1_rty", 32'(m1_rty), 32'((owner == 1) & sr));
    check("m0_dat_i", m0_dat_i, sd);
    check("m1_dat_i", m1_dat_i, sd);
    check("state", 32'(dbg_state), 32'(owner + 1));
    @(posedge clk);
    if (!rst) begin
      owner = -1; last = 1;
`ifdef WB_ARB_TIMEOUT_EN
      cnt = 0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if (owner >= 0 && mc[owner] && ms[owner] && !(sa || se || sr) && !tmo)
        cnt = (cnt < 255) ? cnt + 1 : 255;
      else
        cnt = 0;
`endif
      if (owner < 0) begin
        if (mc[0] && mc[1]) owner = 1 - last;   // the one not served last
        else if (mc[0])     owner = 0;
        else if (mc[1])     owner = 1;
      end else if (!mc[owner]) begin
        last  = owner;
        owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  function automatic logic [2:0] rand_cti();
    case ($urandom_range(0, 2))
      0:       return 3'b000;
      1:       return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  task automatic rand_master(input int i);
    if (mc[i]) begin
      if ($urandom_range(0, 5) == 0) begin
        mc[i] = 1'b0;
        ms[i] = ($urandom_range(0, 3) == 0);
      end else begin
        ms[i] = 1'($urandom_range(0, 1));
      end
    end else begin
      mc[i] = ($urandom_range(0, 3) == 0);
      ms[i] = ($urandom_range(0, 2) == 0);   // sometimes STB without CYC
    end
    ma[i] = $urandom; md[i] = $urandom; mw[i] = 1'($urandom_range(0, 1)); mt[i] = rand_cti();
  endtask

  task automatic rand_slave();
    int r;
    r = $urandom_range(0, 5);
    set_s(r <= 1, r == 2, r == 3, $urandom);
  endtask

  initial begin
    owner = -1; last = 1; tmo = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt = 0;
`endif
    idle_all();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // reset state, with requesters quiet and reset still held
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    cycle();
    rst = 1'b1;

    // single m0 read, ACK on the second strobe cycle
    do_reset();
    set_m(0, 1, 1, 0, 32'h0000_0100, '0, 3'b000);
    #1 check("r025_lat_idle", 32'(s_cyc), 32'd0);
    cycle();
    #1 check("r025_s_cyc", 32'(s_cyc), 32'd1);
    check("r025_s_adr", s_adr, 32'h0000_0100);
    cycle();
    set_s(1, 0, 0, 32'hDEAD_BEEF);
    #1 check("r025_ack", 32'(m0_ack), 32'd1);
    check("r025_data", m0_dat_i, 32'hDEAD_BEEF);
    cycle();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    cycle();
    #1 check("r025_idle", 32'(dbg_state), 32'd0);

    // simultaneous requests: m0 first, idle gap, then m1; then alternation
    do_reset();
    set_m(0, 1, 1, 0, 32'h10, '0, '0);
    set_m(1, 1, 1, 1, 32'h20, 32'h55, '0);
    cycle();
    set_s(1, 0, 0, 32'h1111);
    #1 check("r026_first_m0", 32'(dbg_state), 32'd1);
    check("r026_m1_no_ack", 32'(m1_ack), 32'd0);
    cycle();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    cycle();
    #1 check("r026_gap", 32'(dbg_state), 32'd0);
    check("r026_gap_cyc", 32'(s_cyc), 32'd0);
    cycle();
    #1 check("r026_then_m1", 32'(dbg_state), 32'd2);
    check("r026_m1_adr", s_adr, 32'h20);
    set_m(1, 0, 0, 0, '0, '0, '0);
    cycle();
    set_m(0, 1, 1, 0, 32'h30, '0, '0);
    set_m(1, 1, 1, 0, 32'h40, '0, '0);
    cycle();
    #1 check("r026_tie2_m0", 32'(dbg_state), 32'd1);
    idle_all();
    cycle();
    cycle();

    // m1 4-beat burst, m0 requests at beat 2, no preemption
    do_reset();
    set_m(1, 1, 1, 0, 32'h200, '0, 3'b010);
    cycle();
    for (int b = 0; b < 4; b++) begin
      logic [31:0] d;
      mt[1] = (b == 3) ? 3'b111 : 3'b010;
      ma[1] = 32'h200 + 32'(4 * b);
      if (b == 1) set_m(0, 1, 1, 0, 32'h300, '0, '0);
      d = $urandom;
      set_s(1, 0, 0, d);
      exp_q.push_back(d);
      #1 check("r027_m0_ack", 32'(m0_ack), 32'd0);
      check("r027_m1_ack", 32'(m1_ack), 32'd1);
      if (exp_q.size() > 0) check("r027_data", m1_dat_i, exp_q.pop_front());
      cycle();
    end
    set_m(1, 0, 0, 0, '0, '0, '0);
    set_s(0, 0, 0, '0);
    cycle();
    #1 check("r027_gap", 32'(dbg_state), 32'd0);
    check("r027_q_empty", 32'(exp_q.size()), 32'd0);
    cycle();
    #1 check("r027_m0_gnt", 32'(dbg_state), 32'd1);
    idle_all();
    cycle();
    cycle();

    // reset during a stalled m1 strobe abandons the transfer silently
    do_reset();
    set_m(1, 1, 1, 1, 32'h400, 32'h77, '0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1 check("r028_s_cyc", 32'(s_cyc), 32'd0);
    check("r028_state", 32'(dbg_state), 32'd0);
    check("r028_m1_ack", 32'(m1_ack), 32'd0);
    check("r028_m1_err", 32'(m1_err), 32'd0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    cycle();
    cycle();

    // slave never answers m0's write
    do_reset();
    set_m(0, 1, 1, 1, 32'h500, 32'hA5A5_A5A5, '0);
    cycle();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      #1;
      if (k < TMO) begin
        check("r029_no_err", 32'(m0_err), 32'd0);
        check("r029_stb", 32'(s_stb), 32'd1);
      end else begin
        check("r029_err", 32'(m0_err), 32'd1);
        check("r029_stb_low", 32'(s_stb), 32'd0);
      end
      cycle();
    end
    ms[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("r029_hold", 32'(dbg_state), 32'd1);
      check("r029_err_once", 32'(m0_err), 32'd0);
      cycle();
    end
    mc[0] = 1'b0;
    cycle();
    #1 check("r029_release", 32'(dbg_state), 32'd0);
`else
    begin
      int err_n = 0;
      int stb_lo = 0;
      for (int k = 0; k < 1000; k++) begin
        #1;
        if (m0_err) err_n++;
        if (!s_stb) stb_lo++;
        cycle();
      end
      check("r030_no_err", 32'(err_n), 32'd0);
      check("r030_stb_held", 32'(stb_lo), 32'd0);
    end
`endif
    idle_all();
    cycle();

    // randomized traffic with occasional mid-transfer resets
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      rand_master(0);
      rand_master(1);
      rand_slave();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
